// File: rtl/spi_sample_fifo_if.sv
// Stream bundle between the SPI reader, the sample FIFO and the AXI-side consumer.
//
// Handshake semantics, in one place:
//   in_valid  : one-cycle strobe from the producer. It cannot be stalled, so the
//               word is either stored or dropped in the same cycle.
//   out_valid : out_data holds a word. A transfer happens on every rising edge
//               where out_valid & out_ready are both 1. While out_valid=1 and
//               out_ready=0, out_data and out_valid hold steady.
interface spi_sample_fifo_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // Producer/consumer side, used by whoever drives and drains the FIFO
   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   // FIFO side
   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/spi_sample_fifo.sv
// Sample FIFO behind the SPI reader. It captures single-cycle sample strobes
// into a circular RAM and presents them on a registered valid/ready stream.
// Words that arrive while the FIFO is full are dropped (newest is lost), and
// each drop is counted in a saturating counter and a sticky overflow flag.
//
// Organisation: the head-of-queue word lives in the out_data register. The
// RAM holds only the words behind it. Whenever the head register is empty or
// being consumed, it refills from the RAM. If the RAM is empty, it takes the
// incoming word directly, which gives 1-cycle latency from push to out_valid.
// level counts the head register plus the RAM, so the total capacity is DEPTH.
module spi_sample_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH_LOG2 = 4,
   parameter int DROP_WIDTH = 16
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_areset,
   spi_sample_fifo_if.slave      bus,
   input  logic                  clr_status,
   input  logic                  flush,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic [DROP_WIDTH-1:0] drop_count
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   // level value when the FIFO holds DEPTH words
   localparam logic [PW-1:0]         LP_FULL     = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PW-1:0]         LP_ONE      = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [PW-1:0]         LP_ZERO     = '0;
   localparam logic [DROP_WIDTH-1:0] LP_DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};

   // Storage and pointers. The pointer MSB is a wrap bit, so equal pointers
   // always mean "RAM empty". The RAM never holds more than DEPTH-1 words,
   // because one stored word always sits in the head register.
   logic [DATA_WIDTH-1:0] r_ram [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;

   // Registered outputs
   logic [DATA_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic [PW-1:0]         r_level;
   logic                  r_overflow;
   logic [DROP_WIDTH-1:0] r_drop_count;

   // Per-cycle decisions
   logic                  w_pop;
   logic                  w_full;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_ram_empty;
   logic                  w_load_head;
   logic                  w_from_ram;
   logic                  w_bypass;
   logic                  w_ram_write;
   logic                  w_drop_sat;
   logic [DATA_WIDTH-1:0] w_ram_head;

   // Event decode. Flush wins over push and pop. A push is accepted when
   // there is room, or when a pop frees a slot in the same cycle.
   always_comb begin
      w_pop       = r_out_valid & bus.out_ready;
      w_full      = (r_level == LP_FULL);
      w_ram_empty = (r_wr_ptr == r_rd_ptr);
      w_push      = bus.in_valid & ~flush & (~w_full | w_pop);
      w_drop      = bus.in_valid & ~flush & w_full & ~w_pop;
      // The head register needs a new word when it is empty or being consumed.
      w_load_head = ~flush & (~r_out_valid | w_pop);
      w_from_ram  = w_load_head & ~w_ram_empty;
      // With the RAM empty, the incoming word goes straight to the head
      // register, so order is preserved and the RAM is bypassed.
      w_bypass    = w_load_head & w_ram_empty & w_push;
      w_ram_write = w_push & ~w_bypass;
      w_drop_sat  = &r_drop_count;
      w_ram_head  = r_ram[r_rd_ptr[DEPTH_LOG2-1:0]];
   end

   // Sample RAM write port. Contents need no reset, because the pointers define validity.
   always_ff @(posedge s00_axi_aclk) begin
      if (w_ram_write) begin
         r_ram[r_wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
      end
   end

   // Read/write pointers. Flush discards the stored words by catching up the read pointer.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_wr_ptr <= LP_ZERO;
         r_rd_ptr <= LP_ZERO;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_ram_write) begin
            r_wr_ptr <= r_wr_ptr + LP_ONE;
         end
         if (w_from_ram) begin
            r_rd_ptr <= r_rd_ptr + LP_ONE;
         end
      end
   end

   // Head register. It changes only when empty, consumed or flushed, so it holds steady under backpressure.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_from_ram) begin
         r_out_data  <= w_ram_head;
         r_out_valid <= 1'b1;
      end else if (w_bypass) begin
         r_out_data  <= bus.in_data;
         r_out_valid <= 1'b1;
      end else if (w_load_head) begin
         r_out_valid <= 1'b0;
      end
   end

   // Occupancy counter: +1 on push only, -1 on pop only, unchanged otherwise.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_level <= LP_ZERO;
      end else if (flush) begin
         r_level <= LP_ZERO;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LP_ONE;
            2'b01:   r_level <= r_level - LP_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // Drop status. A drop in the same cycle as clr_status wins, so the clear leaves one recorded drop.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (clr_status) begin
         r_overflow   <= w_drop;
         r_drop_count <= w_drop ? LP_DROP_ONE : '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (!w_drop_sat) begin
            r_drop_count <= r_drop_count + LP_DROP_ONE;
         end
      end
   end

   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign level         = r_level;
   assign overflow      = r_overflow;
   assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_spi_sample_fifo.sv
// Randomized and directed bench for spi_sample_fifo. Two instances share the
// same stimulus: one uses the default 16-bit drop counter and one uses a 4-bit
// counter, so saturation can be reached quickly. The reference is a word queue
// plus an unbounded drop tally, updated from the FIFO rules once per cycle.
module tb_spi_sample_fifo;

   localparam int DW    = 16;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst      = 1'b1;
   logic [DW-1:0] t_data   = '0;
   logic          t_valid  = 1'b0;
   logic          t_ready  = 1'b0;
   logic          t_clr    = 1'b0;
   logic          t_flush  = 1'b0;

   spi_sample_fifo_if #(.DATA_WIDTH(DW)) bus_a ();
   spi_sample_fifo_if #(.DATA_WIDTH(DW)) bus_b ();

   assign bus_a.in_data   = t_data;
   assign bus_a.in_valid  = t_valid;
   assign bus_a.out_ready = t_ready;
   assign bus_b.in_data   = t_data;
   assign bus_b.in_valid  = t_valid;
   assign bus_b.out_ready = t_ready;

   logic [DL2:0] level_a, level_b;
   logic         ovf_a, ovf_b;
   logic [15:0]  drops_a;
   logic [3:0]   drops_b;

   spi_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .DROP_WIDTH(16)) dut_a (
      .s00_axi_aclk  (clk),
      .s00_axi_areset(rst),
      .bus           (bus_a),
      .clr_status    (t_clr),
      .flush         (t_flush),
      .level         (level_a),
      .overflow      (ovf_a),
      .drop_count    (drops_a)
   );

   spi_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .DROP_WIDTH(4)) dut_b (
      .s00_axi_aclk  (clk),
      .s00_axi_areset(rst),
      .bus           (bus_b),
      .clr_status    (t_clr),
      .flush         (t_flush),
      .level         (level_b),
      .overflow      (ovf_b),
      .drop_count    (drops_b)
   );

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   bit            m_ovf   = 1'b0;
   int unsigned   m_drops = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input int unsigned v, input int unsigned max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic compare_all();
      check("valid_a", 32'(bus_a.out_valid), 32'(exp_q.size() != 0));
      check("valid_b", 32'(bus_b.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("data_a", 32'(bus_a.out_data), 32'(exp_q[0]));
         check("data_b", 32'(bus_b.out_data), 32'(exp_q[0]));
      end
      check("level_a", 32'(level_a), 32'(exp_q.size()));
      check("level_b", 32'(level_b), 32'(exp_q.size()));
      check("ovf_a",   32'(ovf_a),   32'(m_ovf));
      check("ovf_b",   32'(ovf_b),   32'(m_ovf));
      check("drops_a", 32'(drops_a), sat(m_drops, 16'hFFFF));
      check("drops_b", 32'(drops_b), sat(m_drops, 4'hF));
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs, advances the reference by the FIFO rules,
   // then samples both DUTs 1 time unit after the edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                       input logic clr, input logic fl, input logic rs);
      bit pop;
      bit drop;
      int sz;
      t_valid = v;
      t_data  = d;
      t_ready = rdy;
      t_clr   = clr;
      t_flush = fl;
      rst     = rs;
      sz   = exp_q.size();
      pop  = (sz > 0) && rdy;
      drop = 1'b0;
      if (rs) begin
         exp_q.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         if (fl) begin
            exp_q.delete();
         end else begin
            if (pop) void'(exp_q.pop_front());
            if (v) begin
               if (sz < DEPTH || pop) exp_q.push_back(d);
               else drop = 1'b1;
            end
         end
         if (clr) begin
            m_ovf   = drop;
            m_drops = drop ? 1 : 0;
         end else if (drop) begin
            m_ovf = 1'b1;
            m_drops++;
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic push(input logic [DW-1:0] d, input logic rdy);
      step(1'b1, d, rdy, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, '0, rdy, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fill16(input logic [DW-1:0] base);
      for (int i = 0; i < DEPTH; i++) push(base + DW'(i), 1'b0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      int p_in, p_rdy;
      // Reset, including one reset cycle with a strobe present
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1);

      // 1: single word with backpressure, then hold
      push(16'h1234, 1'b0);
      repeat (5) idle(1'b0);
      repeat (2) idle(1'b1);

      // 2: 16 words in, drain in order
      fill16(16'h0001);
      repeat (17) idle(1'b1);

      // 3: overflow by 3, drain, clear status
      fill16(16'h0001);
      push(16'hAAAA, 1'b0);
      push(16'hBBBB, 1'b0);
      push(16'hCCCC, 1'b0);
      repeat (17) idle(1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 4: push and pop together at full
      fill16(16'h0100);
      push(16'h5555, 1'b1);
      repeat (17) idle(1'b1);

      // 5: saturate the 4-bit counter, then a clear that collides with a drop
      fill16(16'h0200);
      for (int i = 0; i < 20; i++) push(16'hE000 + DW'(i), 1'b0);
      step(1'b1, 16'hF00D, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (17) idle(1'b1);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 6: flush with a simultaneous strobe, then reset with 8 words stored
      for (int i = 0; i < 6; i++) push(16'h0300 + DW'(i), 1'b0);
      step(1'b1, 16'h0BAD, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      for (int i = 0; i < 8; i++) push(16'h0400 + DW'(i), 1'b0);
      step(1'b1, 16'h0BAD, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      // Random traffic in segments with varying fill/drain bias
      for (int seg = 0; seg < 15; seg++) begin
         p_in  = $urandom_range(10, 95);
         p_rdy = $urandom_range(5, 95);
         for (int c = 0; c < 200; c++) begin
            step(($urandom_range(99) < p_in),
                 DW'($urandom),
                 ($urandom_range(99) < p_rdy),
                 ($urandom_range(49) == 0),
                 ($urandom_range(79) == 0),
                 ($urandom_range(399) == 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
